// File: rtl/lc3_pkg.sv
// Shared LC-3 widths and memory-controller state encoding.
package lc3_pkg;

  localparam int LC3_ADDR_W = 16;
  localparam int LC3_DATA_W = 16;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_WRITE   = 3'd2;
  localparam logic [2:0] ST_RECOVER = 3'd3;
  localparam logic [2:0] ST_RDWAIT  = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_SETUP   = ST_SETUP,
    S_WRITE   = ST_WRITE,
    S_RECOVER = ST_RECOVER,
    S_RDWAIT  = ST_RDWAIT,
    S_DONE    = ST_DONE
  } state_t;

endpackage

// File: rtl/lc3_mem_ctrl_if.sv
// Datapath request/response and ram-side bus of the LC-3 memory controller.
interface lc3_mem_ctrl_if
  import lc3_pkg::*;
#(
  parameter int ADDR_SIZE = LC3_ADDR_W,
  parameter int DATA_SIZE = LC3_DATA_W
);
  logic                 REQ_VALID;
  logic                 REQ_WRITE;
  logic [ADDR_SIZE-1:0] REQ_ADDR;
  logic [DATA_SIZE-1:0] REQ_WDATA;
  logic                 REQ_READY;
  logic                 RESP_VALID;
  logic [DATA_SIZE-1:0] RESP_RDATA;
  logic                 MEM_WE;
  logic [ADDR_SIZE-1:0] MEM_ADDRESS;
  logic [DATA_SIZE-1:0] MEM_DATA_IN;
  logic [DATA_SIZE-1:0] MEM_DATA_OUT;

  modport slave (
    input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, MEM_DATA_OUT,
    output REQ_READY, RESP_VALID, RESP_RDATA, MEM_WE, MEM_ADDRESS, MEM_DATA_IN
  );

  modport master (
    output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, MEM_DATA_OUT,
    input  REQ_READY, RESP_VALID, RESP_RDATA, MEM_WE, MEM_ADDRESS, MEM_DATA_IN
  );
endinterface

// File: rtl/lc3_mem_ctrl_cnt.sv
// 4-bit loadable down-counter with zero flag; load wins over decrement.
// Saturates at zero so a stray decrement cannot wrap.
module lc3_mem_ctrl_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);
  logic [3:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);
endmodule

// File: rtl/lc3_mem_ctrl.sv
// Sequences one LC-3 ram access at a time with address/data setup and hold around MEM_WE.
// Latency accept->RESP_VALID: write 3+WR_PULSE, read 2+RD_WAIT cycles; REQ_READY low while busy.
module lc3_mem_ctrl
  import lc3_pkg::*;
#(
  parameter int ADDR_SIZE = LC3_ADDR_W,
  parameter int DATA_SIZE = LC3_DATA_W,
  parameter int WR_PULSE  = 1,
  parameter int RD_WAIT   = 1
) (
  input  logic           CLK,
  input  logic           RST_N,
  lc3_mem_ctrl_if.slave  bus
);
  if (WR_PULSE < 1 || WR_PULSE > 15) begin : g_bad_wr_pulse
    $error("lc3_mem_ctrl: WR_PULSE must be in 1..15");
  end
  if (RD_WAIT < 1 || RD_WAIT > 15) begin : g_bad_rd_wait
    $error("lc3_mem_ctrl: RD_WAIT must be in 1..15");
  end

  localparam logic [3:0] WR_LOAD = 4'(WR_PULSE - 1);
  localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);

  state_t               state, state_n;
  logic [ADDR_SIZE-1:0] mar, mar_n;
  logic [DATA_SIZE-1:0] mdr, mdr_n, rdata, rdata_n;
  logic                 is_wr, is_wr_n;
  logic                 mem_we, req_ready, resp_valid;
  logic                 cnt_load, cnt_dec, cnt_zero;
  logic [3:0]           cnt_val;

  lc3_mem_ctrl_cnt u_cnt (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_n  = state;
    mar_n    = mar;
    mdr_n    = mdr;
    rdata_n  = rdata;
    is_wr_n  = is_wr;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = 4'd0;
    case (state)
      S_IDLE: begin
        if (bus.REQ_VALID) begin
          mar_n   = bus.REQ_ADDR;
          is_wr_n = bus.REQ_WRITE;
          if (bus.REQ_WRITE) mdr_n = bus.REQ_WDATA;
          state_n = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_load = 1'b1;
        cnt_val  = is_wr ? WR_LOAD : RD_LOAD;
        state_n  = is_wr ? S_WRITE : S_RDWAIT;
      end
      S_WRITE: begin
        if (cnt_zero) state_n = S_RECOVER;
        else          cnt_dec = 1'b1;
      end
      S_RECOVER: state_n = S_DONE;
      S_RDWAIT: begin
        if (cnt_zero) begin
          mdr_n   = bus.MEM_DATA_OUT;
          rdata_n = bus.MEM_DATA_OUT;
          state_n = S_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are registered copies decoded from the next state, so they track state without comb paths.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      mar        <= '0;
      mdr        <= '0;
      rdata      <= '0;
      is_wr      <= 1'b0;
      mem_we     <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
    end else begin
      state      <= state_n;
      mar        <= mar_n;
      mdr        <= mdr_n;
      rdata      <= rdata_n;
      is_wr      <= is_wr_n;
      mem_we     <= (state_n == S_WRITE);
      req_ready  <= (state_n == S_IDLE);
      resp_valid <= (state_n == S_DONE);
    end
  end

  assign bus.REQ_READY   = req_ready;
  assign bus.RESP_VALID  = resp_valid;
  assign bus.RESP_RDATA  = rdata;
  assign bus.MEM_WE      = mem_we;
  assign bus.MEM_ADDRESS = mar;
  assign bus.MEM_DATA_IN = mdr;
endmodule
